// File: rtl/dram_pkg.sv
// Shared command/bank-state encodings and default timing for the multi-bank DRAM timing controller.
package dram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        BS_IDLE     = 3'd0,
        BS_ACT_WAIT = 3'd1,
        BS_RD_WAIT  = 3'd2,
        BS_WR_WAIT  = 3'd3,
        BS_PRE_WAIT = 3'd4
    } bank_state_t;

    localparam int DEF_NUM_BANKS    = 4;
    localparam int DEF_T_RCD        = 14;
    localparam int DEF_T_RP         = 14;
    localparam int DEF_T_CL         = 16;
    localparam int DEF_T_CWL        = 12;
    localparam int DEF_T_BURST      = 4;
    localparam int DEF_T_WR         = 16;
    localparam int DEF_T_RFC        = 160;
    localparam int DEF_T_REFI       = 3900;
    localparam int DEF_MAX_POSTPONE = 8;
    localparam int DEF_CNT_W        = 12;

    function automatic logic is_bank_cmd(input logic [2:0] c);
        return (c == CMD_ACT) || (c == CMD_RD) || (c == CMD_WR) || (c == CMD_PRE);
    endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// One bank's timing FSM: a down-counter loaded on command acceptance that
// raises a registered done pulse and returns to IDLE in the same cycle.
module dram_bank_timer
    import dram_pkg::*;
#(
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_CL    = DEF_T_CL,
    parameter int T_CWL   = DEF_T_CWL,
    parameter int T_BURST = DEF_T_BURST,
    parameter int T_WR    = DEF_T_WR,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  cmd_t        cmd_i,
    output bank_state_t state_o,
    output logic        act_done_o,
    output logic        rd_done_o,
    output logic        wr_done_o,
    output logic        pre_done_o,
    output logic        busy_o,
    output logic        rd_win_o,
    output logic        wr_win_o,
    output logic        data_busy_o
);

    // Counter holds (cycles remaining until done); done fires on the edge after cnt==1.
    localparam logic [CNT_W-1:0] LD_ACT    = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_PRE    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RD     = CNT_W'(T_CL + T_BURST - 1);
    localparam logic [CNT_W-1:0] LD_WR     = CNT_W'(T_CWL + T_BURST + T_WR - 1);
    localparam logic [CNT_W-1:0] RD_WIN_HI = CNT_W'(T_BURST);
    localparam logic [CNT_W-1:0] WR_WIN_LO = CNT_W'(T_WR + 1);
    localparam logic [CNT_W-1:0] WR_WIN_HI = CNT_W'(T_WR + T_BURST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    bank_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        if (start_i) begin
            case (cmd_i)
                CMD_ACT: begin state_d = BS_ACT_WAIT; cnt_d = LD_ACT; end
                CMD_RD:  begin state_d = BS_RD_WAIT;  cnt_d = LD_RD;  end
                CMD_WR:  begin state_d = BS_WR_WAIT;  cnt_d = LD_WR;  end
                CMD_PRE: begin state_d = BS_PRE_WAIT; cnt_d = LD_PRE; end
                default: ;
            endcase
        end else if (state_q != BS_IDLE) begin
            if (cnt_q == ONE) begin
                state_d = BS_IDLE;
                cnt_d   = '0;
                done_d  = {state_q == BS_PRE_WAIT, state_q == BS_WR_WAIT,
                           state_q == BS_RD_WAIT,  state_q == BS_ACT_WAIT};
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BS_IDLE;
            cnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign state_o    = state_q;
    assign act_done_o = done_q[0];
    assign rd_done_o  = done_q[1];
    assign wr_done_o  = done_q[2];
    assign pre_done_o = done_q[3];
    assign busy_o     = |cnt_q;

    assign rd_win_o = (state_q == BS_RD_WAIT) && (cnt_q <= RD_WIN_HI);
    assign wr_win_o = (state_q == BS_WR_WAIT) && (cnt_q >= WR_WIN_LO) && (cnt_q <= WR_WIN_HI);
    // A write stops holding the shared data path once its last data beat is reached.
    assign data_busy_o = (state_q == BS_RD_WAIT) ||
                         ((state_q == BS_WR_WAIT) && (cnt_q > WR_WIN_LO));

endmodule

// File: rtl/dram_timing_ctrl_mb.sv
// Multi-bank DRAM timing controller: per-bank timers, shared data-path arbitration,
// global REF recovery and refresh-interval credit tracking.
module dram_timing_ctrl_mb
    import dram_pkg::*;
#(
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_CL         = DEF_T_CL,
    parameter int T_CWL        = DEF_T_CWL,
    parameter int T_BURST      = DEF_T_BURST,
    parameter int T_WR         = DEF_T_WR,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int T_REFI       = DEF_T_REFI,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         init_done,
    input  logic                         cmd_valid,
    input  logic [2:0]                   cmd_type,
    input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    output logic [NUM_BANKS-1:0]         tACT_done,
    output logic [NUM_BANKS-1:0]         tRD_done,
    output logic [NUM_BANKS-1:0]         tWR_done,
    output logic [NUM_BANKS-1:0]         tPRE_done,
    output logic [NUM_BANKS-1:0]         bank_busy,
    output logic                         tREF_done,
    output logic                         rf_req,
    output logic                         rf_urgent,
    output logic                         rd_en,
    output logic                         wr_en,
    output logic                         cmd_err,
    output logic                         ref_overflow
);

    localparam int IW = $clog2(T_REFI);
    localparam int PW = $clog2(MAX_POSTPONE + 1);
    localparam logic [IW-1:0]    I_LAST = IW'(T_REFI - 1);
    localparam logic [IW-1:0]    I_ONE  = IW'(1);
    localparam logic [PW-1:0]    P_MAX  = PW'(MAX_POSTPONE);
    localparam logic [PW-1:0]    P_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    cmd_t                 cmd;
    bank_state_t          bst [NUM_BANKS];
    logic [NUM_BANKS-1:0] idle, data_busy, rd_win, wr_win, start, sel;
    logic                 acc, is_bank, is_data, is_ref, is_unk;
    logic                 bank_ok, ref_ok, ref_acc, wrap;

    logic             err_q, err_d;
    logic             ref_wait_q, ref_wait_d;
    logic             ref_done_q, ref_done_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]    icnt_q, icnt_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             ovf_q, ovf_d;

    assign cmd     = cmd_t'(cmd_type);
    assign acc     = cmd_valid && init_done;
    assign is_bank = is_bank_cmd(cmd_type);
    assign is_data = (cmd_type == CMD_RD) || (cmd_type == CMD_WR);
    assign is_ref  = (cmd_type == CMD_REF);
    assign is_unk  = (cmd_type > CMD_REF);
    assign sel     = NUM_BANKS'(1) << cmd_bank;

    // Only other banks can block the data path; the target bank is already checked for IDLE.
    assign bank_ok = idle[cmd_bank] && !ref_wait_q && !(is_data && |(data_busy & ~sel));
    assign ref_ok  = (&idle) && !ref_wait_q;
    assign start   = (acc && is_bank && bank_ok) ? sel : '0;
    assign ref_acc = acc && is_ref && ref_ok;
    assign err_d   = acc && (is_unk || (is_bank && !bank_ok) || (is_ref && !ref_ok));

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        dram_bank_timer #(
            .T_RCD  (T_RCD),
            .T_RP   (T_RP),
            .T_CL   (T_CL),
            .T_CWL  (T_CWL),
            .T_BURST(T_BURST),
            .T_WR   (T_WR),
            .CNT_W  (CNT_W)
        ) u_timer (
            .clk_i      (CLK),
            .rst_ni     (nRST),
            .start_i    (start[g]),
            .cmd_i      (cmd),
            .state_o    (bst[g]),
            .act_done_o (tACT_done[g]),
            .rd_done_o  (tRD_done[g]),
            .wr_done_o  (tWR_done[g]),
            .pre_done_o (tPRE_done[g]),
            .busy_o     (bank_busy[g]),
            .rd_win_o   (rd_win[g]),
            .wr_win_o   (wr_win[g]),
            .data_busy_o(data_busy[g])
        );
        assign idle[g] = (bst[g] == BS_IDLE);
    end

    always_comb begin
        ref_wait_d = ref_wait_q;
        ref_cnt_d  = ref_cnt_q;
        ref_done_d = 1'b0;
        if (ref_acc) begin
            ref_wait_d = 1'b1;
            ref_cnt_d  = LD_RFC;
        end else if (ref_wait_q) begin
            if (ref_cnt_q == C_ONE) begin
                ref_wait_d = 1'b0;
                ref_cnt_d  = '0;
                ref_done_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q - C_ONE;
            end
        end
    end

    assign wrap   = init_done && (icnt_q == I_LAST);
    assign icnt_d = (!init_done || wrap) ? '0 : icnt_q + I_ONE;

    // A wrap and an accepted REF in the same cycle cancel, so no credit is lost.
    always_comb begin
        pcnt_d = pcnt_q;
        ovf_d  = ovf_q;
        if (wrap && !ref_acc) begin
            if (pcnt_q == P_MAX) ovf_d  = 1'b1;
            else                 pcnt_d = pcnt_q + P_ONE;
        end else if (ref_acc && !wrap && (pcnt_q != '0)) begin
            pcnt_d = pcnt_q - P_ONE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q      <= 1'b0;
            ref_wait_q <= 1'b0;
            ref_done_q <= 1'b0;
            ref_cnt_q  <= '0;
            icnt_q     <= '0;
            pcnt_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            err_q      <= err_d;
            ref_wait_q <= ref_wait_d;
            ref_done_q <= ref_done_d;
            ref_cnt_q  <= ref_cnt_d;
            icnt_q     <= icnt_d;
            pcnt_q     <= pcnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tREF_done    = ref_done_q;
    assign rf_req       = |pcnt_q;
    assign rf_urgent    = (pcnt_q == P_MAX);
    assign rd_en        = |rd_win;
    assign wr_en        = |wr_win;
    assign cmd_err      = err_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_dram_timing_ctrl_mb.sv
// Directed bench for dram_timing_ctrl_mb: per-cycle vector table plus hand sequences
// for mid-operation reset and refresh-credit saturation.
module tb_dram_timing_ctrl_mb;

    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                           C_PRE = 3'd4, C_REF = 3'd5;
    localparam logic [3:0] Z = 4'h0;
    // misc field: {tREF_done, rf_req, rf_urgent, rd_en, wr_en, cmd_err, ref_overflow}
    localparam logic [6:0] M0 = 7'b0000000, M_REFD = 7'b1000000, M_RD = 7'b0001000,
                           M_WR = 7'b0000100, M_ERR = 7'b0000010;

    logic       CLK, nRST, init_done, cmd_valid;
    logic [2:0] cmd_type;
    logic [1:0] cmd_bank;
    logic [3:0] tACT_done, tRD_done, tWR_done, tPRE_done, bank_busy;
    logic       tREF_done, rf_req, rf_urgent, rd_en, wr_en, cmd_err, ref_overflow;
    logic [26:0] outs;

    dram_timing_ctrl_mb dut (
        .CLK(CLK), .nRST(nRST), .init_done(init_done), .cmd_valid(cmd_valid),
        .cmd_type(cmd_type), .cmd_bank(cmd_bank),
        .tACT_done(tACT_done), .tRD_done(tRD_done), .tWR_done(tWR_done),
        .tPRE_done(tPRE_done), .bank_busy(bank_busy), .tREF_done(tREF_done),
        .rf_req(rf_req), .rf_urgent(rf_urgent), .rd_en(rd_en), .wr_en(wr_en),
        .cmd_err(cmd_err), .ref_overflow(ref_overflow)
    );

    assign outs = {tACT_done, tRD_done, tWR_done, tPRE_done, bank_busy,
                   tREF_done, rf_req, rf_urgent, rd_en, wr_en, cmd_err, ref_overflow};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          n;
        logic        init;
        logic        v;
        logic [2:0]  t;
        logic [1:0]  b;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic        bad;
    logic [26:0] cap;

    function automatic vec_t mk(input int n, input logic init, input logic v,
                                input logic [2:0] t, input logic [1:0] b,
                                input logic [3:0] act, input logic [3:0] rdd,
                                input logic [3:0] wrd, input logic [3:0] pre,
                                input logic [3:0] busy, input logic [6:0] misc);
        vec_t r;
        r.n = n; r.init = init; r.v = v; r.t = t; r.b = b;
        r.exp = {act, rdd, wrd, pre, busy, misc};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) next_cycle();
    endtask

    initial begin
        nRST = 1'b0; init_done = 1'b1; cmd_valid = 1'b1; cmd_type = C_ACT; cmd_bank = 2'd0;

        // init_done low: command ignored; then cycle 0 is the first init_done cycle
        tbl.push_back(mk(1,   0, 1, C_ACT, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(3,   0, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(10,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(1,   1, 1, C_ACT, 2'd2, Z, Z, Z, Z, Z, M0));               // c10
        tbl.push_back(mk(13,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0100, M0));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, 4'b0100, Z, Z, Z, Z, M0));         // c24
        tbl.push_back(mk(1,   1, 1, C_RD,  2'd0, Z, Z, Z, Z, Z, M0));               // c25
        tbl.push_back(mk(4,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0001, M0));
        tbl.push_back(mk(1,   1, 1, C_RD,  2'd1, Z, Z, Z, Z, 4'b0001, M0));         // c30
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0001, M_ERR));
        tbl.push_back(mk(9,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0001, M0));
        tbl.push_back(mk(4,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0001, M_RD));       // c41-44
        tbl.push_back(mk(1,   1, 1, C_WR,  2'd1, Z, 4'b0001, Z, Z, Z, M0));         // c45
        tbl.push_back(mk(11,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M0));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M_WR));       // c57
        tbl.push_back(mk(1,   1, 1, C_RD,  2'd3, Z, Z, Z, Z, 4'b0010, M_WR));       // c58
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M_WR | M_ERR));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M_WR));       // c60
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M0));
        tbl.push_back(mk(1,   1, 1, C_RD,  2'd3, Z, Z, Z, Z, 4'b0010, M0));         // c62
        tbl.push_back(mk(14,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b1010, M0));
        tbl.push_back(mk(1,   1, 1, C_REF, 2'd0, Z, Z, 4'b0010, Z, 4'b1000, M0));   // c77
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b1000, M_RD | M_ERR));
        tbl.push_back(mk(3,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b1000, M_RD));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, 4'b1000, Z, Z, Z, M0));         // c82
        tbl.push_back(mk(1,   1, 1, C_REF, 2'd0, Z, Z, Z, Z, Z, M0));               // c83
        tbl.push_back(mk(16,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(1,   1, 1, C_ACT, 2'd0, Z, Z, Z, Z, Z, M0));               // c100
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M_ERR));
        tbl.push_back(mk(18,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(1,   1, 1, C_REF, 2'd0, Z, Z, Z, Z, Z, M0));               // c120
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M_ERR));
        tbl.push_back(mk(121, 1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M_REFD));           // c243
        tbl.push_back(mk(1,   1, 1, C_PRE, 2'd1, Z, Z, Z, Z, Z, M0));               // c244
        tbl.push_back(mk(13,  1, 0, C_NOP, 2'd0, Z, Z, Z, Z, 4'b0010, M0));
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, 4'b0010, Z, M0));         // c258
        tbl.push_back(mk(1,   1, 1, 3'd7,  2'd0, Z, Z, Z, Z, Z, M0));               // c259
        tbl.push_back(mk(1,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M_ERR));
        tbl.push_back(mk(1,   1, 1, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));
        tbl.push_back(mk(3,   1, 0, C_NOP, 2'd0, Z, Z, Z, Z, Z, M0));

        // Reset state, with a command held on the inputs that must be ignored
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset_state", 32'(outs), 32'd0);
        next_cycle();
        cmd_valid = 1'b0; init_done = 1'b0; cmd_type = C_NOP;
        nRST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bad = 1'b0;
            cap = '0;
            for (int k = 0; k < tbl[i].n; k++) begin
                init_done = tbl[i].init;
                cmd_valid = (k == 0) ? tbl[i].v : 1'b0;
                cmd_type  = tbl[i].t;
                cmd_bank  = tbl[i].b;
                @(negedge CLK);
                if (!bad) begin
                    cap = outs;
                    if (outs !== tbl[i].exp) bad = 1'b1;
                end
                next_cycle();
            end
            chk($sformatf("vec%0d", i), 32'(cap), 32'(tbl[i].exp));
        end

        // Reset in the middle of a write data window
        cmd_valid = 1'b1; cmd_type = C_WR; cmd_bank = 2'd0;
        next_cycle();
        cmd_valid = 1'b0; cmd_type = C_NOP;
        repeat (12) next_cycle();
        #2;
        chk("wr_en_before_rst", 32'(wr_en), 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(outs), 32'd0);
        init_done = 1'b0;
        next_cycle();
        next_cycle();
        nRST = 1'b1;
        init_done = 1'b1;
        cyc = 0;
        bad = 1'b0;
        cap = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (!bad) begin
                cap = outs;
                if (outs !== 27'd0) bad = 1'b1;
            end
            next_cycle();
        end
        chk("no_stale_after_rst", 32'(cap), 32'd0);

        // Refresh credit: first wrap, REF on a wrap cycle, saturation, overflow
        adv_to(3899);
        @(negedge CLK);
        chk("rf_req_c3899", 32'(rf_req), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("rf_req_c3900", 32'(rf_req), 32'd1);

        adv_to(7799);
        cmd_valid = 1'b1; cmd_type = C_REF;
        @(negedge CLK);
        chk("rf_req_c7799", 32'(rf_req), 32'd1);
        next_cycle();
        cmd_valid = 1'b0; cmd_type = C_NOP;
        @(negedge CLK);
        chk("wrap_ref_cancel", 32'({rf_req, cmd_err}), 32'b10);
        adv_to(7958);
        @(negedge CLK);
        chk("ref_done_c7958", 32'(tREF_done), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("ref_done_c7959", 32'(tREF_done), 32'd1);

        adv_to(35099);
        @(negedge CLK);
        chk("urgent_c35099", 32'(rf_urgent), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("urgent_c35100", 32'(rf_urgent), 32'd1);

        adv_to(38999);
        @(negedge CLK);
        chk("ovf_c38999", 32'(ref_overflow), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("ovf_c39000", 32'({ref_overflow, rf_urgent}), 32'b11);

        adv_to(39010);
        cmd_valid = 1'b1; cmd_type = C_REF;
        next_cycle();
        cmd_valid = 1'b0; cmd_type = C_NOP;
        @(negedge CLK);
        chk("ref_after_sat", 32'({ref_overflow, rf_urgent, rf_req, cmd_err}), 32'b1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
